// File: rtl/nway_mem_sched.sv
// Request scheduler for an N-way dual-port memory.
// Clears the memory after reset, then arbitrates one read and one write per cycle.
module nway_mem_sched #(
  parameter int N     = 4,
  parameter int WIDTH = 18,
  parameter int DEPTH = 32,
  parameter int R     = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int WW   = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [R-1:0]         req_valid,
  input  logic [R-1:0]         req_we,
  input  logic [R*WW-1:0]      req_way,
  input  logic [R*AW-1:0]      req_adr,
  input  logic [R*WIDTH-1:0]   req_wdat,
  output logic [R-1:0]         req_ready,
  output logic [R-1:0]         rsp_valid,
  output logic [N*WIDTH-1:0]   rsp_dat,
  output logic                 init_done,
  output logic [N-1:0]         mem_we,
  output logic [AW-1:0]        mem_wad,
  output logic [AW-1:0]        mem_rad,
  output logic [WIDTH-1:0]     mem_wdat,
  input  logic [N*WIDTH-1:0]   mem_rdat
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      cnt_q;
  logic [PW-1:0]      rptr_q, wptr_q, rptr_d, wptr_d;
  logic [R-1:0]       rv_q, rv_d;
  logic               done_q;
  logic               byp_q;
  logic [WW-1:0]      bway_q;
  logic [WIDTH-1:0]   bdat_q;

  logic               run;
  logic [R-1:0]       rd_req, wr_req;
  logic [PW:0]        rd_pick, wr_pick;
  logic               rd_any, wr_any;
  logic [PW-1:0]      rd_id, wr_id;
  logic [WW-1:0]      wway;
  logic [AW-1:0]      wadr, radr;
  logic [WIDTH-1:0]   wdat;
  logic               way_ok, hit;
  logic [N*WIDTH-1:0] merged;

  // First requester at or after the pointer, modulo R.
  function automatic logic [PW:0] rr_pick(
    input logic [R-1:0]  req,
    input logic [PW-1:0] ptr
  );
    logic [PW:0] res;
    int idx;
    res = '0;
    for (int k = R - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % R;
      if (req[idx]) res = {1'b1, idx[PW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(R - 1)) ? '0 : p + PW'(1);
  endfunction

  assign run     = (state_q == RUN);
  assign rd_req  = req_valid & ~req_we;
  assign wr_req  = req_valid & req_we;
  assign rd_pick = rr_pick(rd_req, rptr_q);
  assign wr_pick = rr_pick(wr_req, wptr_q);
  assign rd_any  = run & rd_pick[PW];
  assign wr_any  = run & wr_pick[PW];
  assign rd_id   = rd_pick[PW-1:0];
  assign wr_id   = wr_pick[PW-1:0];

  assign wway   = req_way[wr_id*WW +: WW];
  assign wadr   = req_adr[wr_id*AW +: AW];
  assign wdat   = req_wdat[wr_id*WIDTH +: WIDTH];
  assign radr   = req_adr[rd_id*AW +: AW];
  assign way_ok = (int'(wway) < N);
  assign hit    = rd_any & wr_any & way_ok & (radr == wadr);

  always_comb begin
    state_d   = state_q;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    rv_d      = '0;
    req_ready = '0;
    mem_we    = '0;
    mem_wad   = '0;
    mem_rad   = '0;
    mem_wdat  = '0;
    unique case (state_q)
      INIT: begin
        mem_we  = '1;
        mem_wad = cnt_q;
        if (cnt_q == AW'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        if (rd_any) begin
          req_ready[rd_id] = 1'b1;
          rv_d[rd_id]      = 1'b1;
          mem_rad          = radr;
          rptr_d           = nxt(rd_id);
        end
        if (wr_any) begin
          req_ready[wr_id] = 1'b1;
          mem_wad          = wadr;
          mem_wdat         = wdat;
          wptr_d           = nxt(wr_id);
          if (way_ok) mem_we = N'(1) << wway;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= INIT;
      cnt_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      rv_q    <= '0;
      done_q  <= 1'b0;
      byp_q   <= 1'b0;
      bway_q  <= '0;
      bdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= run ? '0 : cnt_q + AW'(1);
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      rv_q    <= rv_d;
      done_q  <= (state_d == RUN);
      byp_q   <= hit;
      bway_q  <= wway;
      bdat_q  <= wdat;
    end
  end

  // The memory returns pre-write data on a same-cycle collision.
  always_comb begin
    merged = mem_rdat;
    if (byp_q) merged[bway_q*WIDTH +: WIDTH] = bdat_q;
  end

  assign rsp_valid = rv_q;
  assign rsp_dat   = (|rv_q) ? merged : '0;
  assign init_done = done_q;

endmodule

// File: tb/tb_nway_mem_sched.sv
// Directed bench for nway_mem_sched with behavioural memories.
// A second N=3 instance exercises the out-of-range write way.
module tb_nway_mem_sched;

  localparam int W = 18;
  localparam int D = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic [1:0]   valid, we;
  logic [3:0]   way;
  logic [9:0]   adr;
  logic [35:0]  wdat;

  logic [1:0]   ready, rsp_valid;
  logic [71:0]  rsp_dat;
  logic         init_done;
  logic [3:0]   mem_we;
  logic [4:0]   mem_wad, mem_rad;
  logic [17:0]  mem_wdat;
  logic [71:0]  mem_rdat;

  logic [1:0]   r3_ready, r3_rsp_valid;
  logic [53:0]  r3_rsp_dat;
  logic         r3_init_done;
  logic [2:0]   r3_mem_we;
  logic [4:0]   r3_mem_wad, r3_mem_rad;
  logic [17:0]  r3_mem_wdat;
  logic [53:0]  r3_mem_rdat;

  logic [W-1:0] m4 [4][D];
  logic [W-1:0] m3 [3][D];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nway_mem_sched #(.N(4), .WIDTH(W), .DEPTH(D), .R(2)) u_dut (
    .clk(clk), .rstn(rstn),
    .req_valid(valid), .req_we(we), .req_way(way),
    .req_adr(adr), .req_wdat(wdat), .req_ready(ready),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat),
    .init_done(init_done), .mem_we(mem_we),
    .mem_wad(mem_wad), .mem_rad(mem_rad),
    .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
  );

  nway_mem_sched #(.N(3), .WIDTH(W), .DEPTH(D), .R(2)) u_dut3 (
    .clk(clk), .rstn(rstn),
    .req_valid(valid), .req_we(we), .req_way(way),
    .req_adr(adr), .req_wdat(wdat), .req_ready(r3_ready),
    .rsp_valid(r3_rsp_valid), .rsp_dat(r3_rsp_dat),
    .init_done(r3_init_done), .mem_we(r3_mem_we),
    .mem_wad(r3_mem_wad), .mem_rad(r3_mem_rad),
    .mem_wdat(r3_mem_wdat), .mem_rdat(r3_mem_rdat)
  );

  always @(posedge clk) begin
    for (int w = 0; w < 4; w++) begin
      if (mem_we[w]) m4[w][mem_wad] <= mem_wdat;
      mem_rdat[w*W +: W] <= m4[w][mem_rad];
    end
    for (int w = 0; w < 3; w++) begin
      if (r3_mem_we[w]) m3[w][r3_mem_wad] <= r3_mem_wdat;
      r3_mem_rdat[w*W +: W] <= m3[w][r3_mem_rad];
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [1:0] wy, input logic [4:0] a,
                         input logic [17:0] d);
    valid[i]         = v;
    we[i]            = w;
    way[i*2 +: 2]    = wy;
    adr[i*5 +: 5]    = a;
    wdat[i*18 +: 18] = d;
  endtask

  initial begin
    rstn  = 1'b0;
    valid = '0;
    we    = '0;
    way   = '0;
    adr   = '0;
    wdat  = '0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_init_done", init_done, 0);

    // Clear sweep; requests during INIT must be ignored.
    rstn = 1'b1;
    for (int i = 0; i < D; i++) begin
      if (i < D - 1) begin
        set_req(0, 1, 1, 2'd1, 5'd3, 18'h3ff);
        set_req(1, 1, 0, 2'd0, 5'd3, 18'h0);
      end else begin
        valid = '0;
      end
      #1;
      chk("init_we", mem_we, 4'b1111);
      chk("init_wad", mem_wad, i);
      chk("init_wdat", mem_wdat, 0);
      chk("init_ready", ready, 0);
      chk("init_done_lo", init_done, 0);
      @(negedge clk);
    end
    chk("init_done_hi", init_done, 1);
    chk("run_idle_we", mem_we, 0);
    chk("run_idle_rad", mem_rad, 0);

    // Write then read next cycle, no bypass needed.
    set_req(0, 1, 1, 2'd2, 5'd5, 18'h155);
    #1;
    chk("wr_ready", ready, 2'b01);
    chk("wr_we", mem_we, 4'b0100);
    chk("wr_wad", mem_wad, 5);
    chk("wr_wdat", mem_wdat, 18'h155);
    @(negedge clk);
    valid = '0;
    set_req(1, 1, 0, 2'd0, 5'd5, 18'h0);
    #1;
    chk("rd_ready", ready, 2'b10);
    chk("rd_rad", mem_rad, 5);
    chk("rd_no_rsp", rsp_valid, 0);
    @(negedge clk);
    valid = '0;
    #1;
    chk("rd_rsp_valid", rsp_valid, 2'b10);
    chk("rd_rsp_dat", rsp_dat, 128'h155 << 36);
    @(negedge clk);
    chk("rd_rsp_pulse", rsp_valid, 0);

    // Same-cycle write and read of one address.
    set_req(0, 1, 1, 2'd1, 5'd7, 18'h3aa);
    set_req(1, 1, 0, 2'd0, 5'd7, 18'h0);
    #1;
    chk("hz_ready", ready, 2'b11);
    chk("hz_we", mem_we, 4'b0010);
    @(negedge clk);
    valid = '0;
    #1;
    chk("hz_rsp_valid", rsp_valid, 2'b10);
    chk("hz_rsp_dat", rsp_dat, 128'h3aa << 18);
    @(negedge clk);

    // Continuous reads alternate, each answered one cycle later.
    set_req(0, 1, 0, 2'd0, 5'd3, 18'h0);
    set_req(1, 1, 0, 2'd0, 5'd4, 18'h0);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) valid = '0;
      #1;
      if (k > 0) begin
        chk("rr_rsp", rsp_valid, (k % 2 == 1) ? 2'b01 : 2'b10);
        chk("rr_dat", rsp_dat, 0);
      end
      if (k < 4) begin
        chk("rr_ready", ready, (k % 2 == 0) ? 2'b01 : 2'b10);
        chk("rr_rad", mem_rad, (k % 2 == 0) ? 5'd3 : 5'd4);
      end
      @(negedge clk);
    end
    chk("rr_idle", rsp_valid, 0);

    // Way 3 is valid for N=4 but out of range for N=3.
    set_req(0, 1, 1, 2'd3, 5'd9, 18'h2ab);
    #1;
    chk("oor_ready", r3_ready, 2'b01);
    chk("oor_we", r3_mem_we, 0);
    chk("w3_we", mem_we, 4'b1000);
    @(negedge clk);
    valid = '0;
    set_req(1, 1, 0, 2'd0, 5'd9, 18'h0);
    #1;
    chk("oor_rd_ready", r3_ready, 2'b10);
    @(negedge clk);
    valid = '0;
    #1;
    chk("oor_rsp_valid", r3_rsp_valid, 2'b10);
    chk("oor_rsp_dat", r3_rsp_dat, 0);
    chk("w3_rsp_dat", rsp_dat, 128'h2ab << 54);
    @(negedge clk);

    // Reset lands on the edge that would launch a response.
    set_req(0, 1, 0, 2'd0, 5'd5, 18'h0);
    #1;
    chk("rst_rd_ready", ready, 2'b01);
    rstn = 1'b0;
    @(negedge clk);
    valid = '0;
    #1;
    chk("rst_drop_rsp", rsp_valid, 0);
    chk("rst_init_lo", init_done, 0);
    chk("rst_we", mem_we, 4'b1111);
    chk("rst_wad", mem_wad, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("re_wad", mem_wad, i);
      chk("re_rsp", rsp_valid, 0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
